// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite command master: response codes, FSM states,
// and the GPIO control slave register map.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] GPIO_LED  = 4'h0;
  localparam logic [3:0] GPIO_SW   = 4'h4;
  localparam logic [3:0] GPIO_REG2 = 4'h8;
  localparam logic [3:0] GPIO_REG3 = 4'hC;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  // States in which the per-transaction cycle counter advances.
  function automatic logic state_counts(input state_e s);
    return (s == StWr) || (s == StWrResp) || (s == StRdAddr) || (s == StRdData);
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that turns single-word local commands into one outstanding
// read or write transaction and returns data/response on a valid/ready port.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,

  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_write,

  output logic                              busy,
  output logic                              timeout_err,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam logic [31:0] TimeoutVal = 32'(TIMEOUT_CYCLES);
  localparam logic        TimeoutEn  = (TIMEOUT_CYCLES != 0);

  state_e                            r_state;
  logic                              r_cmd_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_bready;
  logic                              r_arvalid;
  logic                              r_rready;
  logic                              r_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                        r_rsp_resp;
  logic                              r_rsp_write;
  logic [31:0]                       r_cnt;
  logic                              r_timeout_err;

  logic        w_cmd_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic [31:0] w_cnt_inc;

  always_comb begin
    w_cmd_hs  = cmd_valid & r_cmd_ready;
    w_aw_hs   = r_awvalid & M_AXI_AWREADY;
    w_w_hs    = r_wvalid & M_AXI_WREADY;
    // A channel is finished if it already handshook earlier or does so this cycle.
    w_aw_fin  = ~r_awvalid | w_aw_hs;
    w_w_fin   = ~r_wvalid | w_w_hs;
    w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state       <= StIdle;
      r_cmd_ready   <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_write   <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // Timeout only flags; the transaction keeps running to stay protocol-clean.
      if (state_counts(r_state)) begin
        r_cnt <= w_cnt_inc;
        if (TimeoutEn && (w_cnt_inc == TimeoutVal)) begin
          r_timeout_err <= 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_hs) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= cmd_addr;
            r_wdata       <= cmd_wdata;
            r_wstrb       <= cmd_wstrb;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= StWr;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= StRdAddr;
            end
          end
        end

        StWr: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= StWrResp;
          end
        end

        StWrResp: begin
          if (M_AXI_BVALID && r_bready) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_rdata <= '0;
            r_rsp_write <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= StRsp;
          end
        end

        StRdAddr: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdData;
          end
        end

        StRdData: begin
          if (M_AXI_RVALID && r_rready) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= M_AXI_RDATA;
            r_rsp_resp  <= M_AXI_RRESP;
            r_rsp_write <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= StRsp;
          end
        end

        StRsp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_write     = r_rsp_write;
  assign busy          = (r_state != StIdle);
  assign timeout_err   = r_timeout_err;

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master; the AXI slave side is driven step by step.
module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, timeout_err;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int          n_cmp;
  int          n_err;
  logic [31:0] tb_leds;
  logic [31:0] tb_switches;

  axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(4),
    .TIMEOUT_CYCLES    (8)
  ) u_dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_write    (rsp_write),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one command for a single edge; caller guarantees cmd_ready is high.
  task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    tb_leds = 32'h0;
    tb_switches = 32'h0000_003C;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = RESP_OKAY;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = RESP_OKAY;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_prot", 32'({awprot, arprot}), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Write 0xA5 to the LED register
    send_cmd(1'b1, GPIO_LED, 32'h0000_00A5, 4'hF);
    chk("wr1_awvalid", 32'(awvalid), 1);
    chk("wr1_wvalid", 32'(wvalid), 1);
    chk("wr1_awaddr", 32'(awaddr), 32'(GPIO_LED));
    chk("wr1_wstrb", 32'(wstrb), 32'hF);
    chk("wr1_busy", 32'(busy), 1);
    chk("wr1_cmd_ready", 32'(cmd_ready), 0);
    awready = 1'b1; wready = 1'b1;
    if (awvalid && wvalid && awaddr == GPIO_LED) tb_leds = wdata;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk("wr1_leds", tb_leds, 32'h0000_00A5);
    chk("wr1_aw_drop", 32'({awvalid, wvalid}), 0);
    chk("wr1_bready", 32'(bready), 1);
    bvalid = 1'b1; bresp = RESP_OKAY;
    tick();
    bvalid = 1'b0;
    chk("wr1_rsp_valid", 32'(rsp_valid), 1);
    chk("wr1_rsp_resp", 32'(rsp_resp), 32'(RESP_OKAY));
    chk("wr1_rsp_write", 32'(rsp_write), 1);
    chk("wr1_bready_drop", 32'(bready), 0);
    take_rsp();
    chk("wr1_rsp_drop", 32'(rsp_valid), 0);
    chk("wr1_cmd_ready_back", 32'(cmd_ready), 1);

    // Read switches
    send_cmd(1'b0, GPIO_SW, 32'h0, 4'h0);
    chk("rd1_arvalid", 32'(arvalid), 1);
    chk("rd1_araddr", 32'(araddr), 32'(GPIO_SW));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("rd1_ar_drop", 32'(arvalid), 0);
    chk("rd1_rready", 32'(rready), 1);
    rvalid = 1'b1; rdata = tb_switches; rresp = RESP_OKAY;
    tick();
    rvalid = 1'b0;
    chk("rd1_rsp_valid", 32'(rsp_valid), 1);
    chk("rd1_rdata", rsp_rdata, 32'h0000_003C);
    chk("rd1_rsp_write", 32'(rsp_write), 0);
    chk("rd1_rready_drop", 32'(rready), 0);
    chk("rd1_one_ar", 32'(arvalid), 0);
    take_rsp();

    // W handshake three cycles before AW
    send_cmd(1'b1, GPIO_REG2, 32'h1234_5678, 4'h3);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("skw1_w_drop", 32'(wvalid), 0);
    chk("skw1_aw_hold", 32'(awvalid), 1);
    tick(); tick();
    chk("skw1_aw_still", 32'(awvalid), 1);
    chk("skw1_no_bready", 32'(bready), 0);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("skw1_aw_drop", 32'(awvalid), 0);
    chk("skw1_bready", 32'(bready), 1);
    bvalid = 1'b1; bresp = RESP_SLVERR;
    tick();
    bvalid = 1'b0;
    chk("skw1_rsp_valid", 32'(rsp_valid), 1);
    chk("skw1_rsp_resp", 32'(rsp_resp), 32'(RESP_SLVERR));
    chk("skw1_rdata0", rsp_rdata, 0);
    take_rsp();

    // AW handshake three cycles before W
    send_cmd(1'b1, GPIO_REG3, 32'hCAFE_0001, 4'hF);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("skw2_aw_drop", 32'(awvalid), 0);
    chk("skw2_w_hold", 32'(wvalid), 1);
    tick(); tick();
    chk("skw2_w_still", 32'(wvalid), 1);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk("skw2_w_drop", 32'(wvalid), 0);
    chk("skw2_bready", 32'(bready), 1);
    bvalid = 1'b1; bresp = RESP_DECERR;
    tick();
    bvalid = 1'b0;
    chk("skw2_rsp_resp", 32'(rsp_resp), 32'(RESP_DECERR));
    chk("skw2_bready_drop", 32'(bready), 0);
    take_rsp();

    // Delayed B and stalled response; a pending read must wait for the handshake
    send_cmd(1'b1, GPIO_LED, 32'h0000_0042, 4'hF);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stl_bready_hold", 32'(bready), 1);
      tick();
    end
    bvalid = 1'b1; bresp = RESP_OKAY;
    tick();
    bvalid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_SW;
    for (int i = 0; i < 4; i++) begin
      chk("stl_rsp_valid", 32'(rsp_valid), 1);
      chk("stl_rsp_payload", {27'h0, rsp_write, rsp_resp, 2'b00}, 32'h10);
      chk("stl_cmd_ready", 32'(cmd_ready), 0);
      chk("stl_no_accept", 32'(arvalid), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("stl_rsp_drop", 32'(rsp_valid), 0);
    chk("stl_cmd_ready_back", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    chk("stl_rd_arvalid", 32'(arvalid), 1);
    chk("stl_rd_cmd_ready", 32'(cmd_ready), 0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    tb_switches = 32'h0000_005A;
    for (int i = 0; i < 5; i++) begin
      chk("stl_rready_hold", 32'(rready), 1);
      tick();
    end
    rvalid = 1'b1; rdata = tb_switches; rresp = RESP_OKAY;
    tick();
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      chk("stl_rd_rdata", rsp_rdata, 32'h0000_005A);
      tick();
    end
    take_rsp();

    // Timeout: ARREADY withheld, counter reaches 8
    send_cmd(1'b0, GPIO_LED, 32'h0, 4'h0);
    chk("to_clear_on_accept", 32'(timeout_err), 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_not_yet", 32'(timeout_err), 0);
    end
    tick();
    chk("to_set", 32'(timeout_err), 1);
    chk("to_arvalid_kept", 32'(arvalid), 1);
    tick(); tick();
    chk("to_sticky", 32'(timeout_err), 1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1122_3344; rresp = RESP_OKAY;
    tick();
    rvalid = 1'b0;
    chk("to_rd_rdata", rsp_rdata, 32'h1122_3344);
    take_rsp();
    chk("to_sticky_idle", 32'(timeout_err), 1);
    send_cmd(1'b1, GPIO_LED, 32'h0000_0001, 4'hF);
    chk("to_cleared", 32'(timeout_err), 0);

    // Reset mid-write with W still pending
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("rstw_wvalid_pending", 32'(wvalid), 1);
    rst = 1'b1;
    tick();
    chk("rstw_valids", 32'({awvalid, wvalid, arvalid}), 0);
    chk("rstw_readies", 32'({bready, rready}), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_rsp_valid", 32'(rsp_valid), 0);
    chk("rstw_rsp_rdata", rsp_rdata, 0);
    chk("rstw_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    tick();
    chk("rstw_cmd_ready_back", 32'(cmd_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- AXI4-Lite master (initiator) that turns single-word commands from local fabric logic into AXI4-Lite read/write transactions.
- Drives the 4-register GPIO control slave, or any AXI4-Lite slave, from PL logic without the PS.
- One outstanding transaction at a time.
- The result (read data and response code) is returned on a valid/ready response port.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 4, AXI address width; matches the GPIO slave register map.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before timeout_err is set; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address, passed to AWADDR/ARADDR unchanged
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  captured BRESP or RRESP
- rsp_write  out  1  echo of cmd_write
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky timeout flag
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset (M_AXI_ARESET=1 at a clock edge):
  - All VALID/READY outputs, rsp_valid, busy and timeout_err go to 0.
  - Address, data, rsp_* and counter registers go to 0.
  - State goes to IDLE.
  - cmd_ready is 0 during reset and 1 from the first cycle after reset deasserts.
  - Reset mid-transaction abandons the transaction. The slave is reset from the same source.
- All AXI outputs are registered. AWPROT and ARPROT are tied to 3'b000.
- States are IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake, latch addr/wdata/wstrb/write.
  - Write: next cycle AWVALID=1 and WVALID=1 simultaneously; go to WR.
  - Read: next cycle ARVALID=1; go to RD_ADDR.
  - Latency from command handshake to VALID is 1 cycle.
- WR:
  - AWVALID drops the cycle after AWREADY is sampled high; WVALID drops independently the cycle after WREADY.
  - Either order is accepted, including both in the same cycle and arbitrary skew.
  - Once both handshakes are done, go to WR_RESP with BREADY=1.
  - BVALID arriving in the same cycle as the last AW/W handshake is not possible (slave rule). A BVALID seen in WR_RESP is accepted.
- WR_RESP: on BVALID && BREADY, capture BRESP, set rsp_rdata=0 and rsp_valid=1, drop BREADY, go to RSP.
- RD_ADDR: on ARREADY, drop ARVALID next cycle, set RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID && RREADY, capture RDATA and RRESP, drop RREADY, set rsp_valid=1, go to RSP.
- RSP:
  - rsp_* held stable until rsp_ready.
  - On handshake, rsp_valid drops and state goes to IDLE, so cmd_ready returns the next cycle.
  - Minimum command-to-command spacing is therefore 1 cycle after the response handshake.
- VALID is never withdrawn before its handshake, and payload is stable while VALID is high.
- Timeout:
  - A 32-bit cycle counter is cleared on command accept and increments in WR, WR_RESP, RD_ADDR and RD_DATA. It saturates; no wrap.
  - When it equals TIMEOUT_CYCLES (nonzero), timeout_err is set.
  - The transaction is NOT abandoned; protocol correctness takes priority.
  - timeout_err clears on the next command accept or on reset.
- A non-OKAY response (SLVERR/DECERR) is reported in rsp_resp only. It is not an error state.

Decomposition:
- Package axil_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The state enum constants.
  - GPIO register offsets: LED=0x0, SW=0x4, REG2=0x8, REG3=0xC.
- Single flat module; no sub-module is warranted.

Test Plan:
- Write cmd addr=0x0, wdata=0x000000A5, wstrb=4'hF against the GPIO slave -> leds=0xA5; rsp_resp=00; rsp_write=1; AWVALID and WVALID rise 1 cycle after accept.
- Switches=0x3C, read cmd addr=0x4 -> rsp_rdata=0x0000003C, rsp_resp=00, one ARVALID handshake.
- Slave model asserts WREADY 3 cycles before AWREADY, then the reverse -> each VALID drops exactly 1 cycle after its own handshake; a single B is accepted; rsp_valid=1.
- Hold BVALID/RVALID off 5 cycles and hold rsp_ready=0 for 4 cycles -> BREADY/RREADY stay high; rsp_* stable; cmd_ready=0 until the rsp handshake, then 1 on the next cycle.
- TIMEOUT_CYCLES=8, slave never asserts ARREADY -> timeout_err=1 on cycle 8; ARVALID still high. Assert ARREADY -> read completes and the next accept clears timeout_err.
- Assert M_AXI_ARESET while WVALID=1 mid-write -> next cycle all VALID/READY=0, busy=0, rsp_valid=0; cmd_ready=1 the cycle after reset release.
